// File: rtl/router_fsm.sv
// router_fsm: ingress packet sequencer; clock/reset, source handshake, FIFO status in; register-block strobes, write enable, busy out
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);
  typedef enum logic [2:0] {DA, LFD, LD, WTE, FFS, LAF, LP, CPE} state_t;
  state_t state, next;
  logic [1:0] addr_q;
  logic [3:0] empty_v, soft_v;
  logic       sel_empty, soft_hit, hdr_ok;
  assign empty_v   = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_v    = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign sel_empty = empty_v[state == DA ? data_in : addr_q];
  assign soft_hit  = soft_v[addr_q] && state != DA;
  assign hdr_ok    = pkt_valid && data_in != 2'b11;
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= DA;
      addr_q <= 2'b00;
    end else begin
      state <= next;
      if (state == DA && hdr_ok) addr_q <= data_in;
    end
  end
  always_comb begin
    next = DA;
    case (state)
      DA:      next = hdr_ok ? (sel_empty ? LFD : WTE) : DA;
      WTE:     next = sel_empty ? LFD : WTE;
      LFD:     next = LD;
      LD:      next = fifo_full ? FFS : (!pkt_valid ? LP : LD);
      FFS:     next = fifo_full ? FFS : LAF;
      LAF:     next = parity_done ? DA : (low_pkt_valid ? LP : LD);
      LP:      next = CPE;
      CPE:     next = fifo_full ? FFS : DA;
      default: next = DA;
    endcase
    if (soft_hit) next = DA;
  end
  assign detect_add    = state == DA;
  assign lfd_state     = state == LFD;
  assign ld_state      = state == LD;
  assign laf_state     = state == LAF;
  assign full_state    = state == FFS;
  assign rst_int_reg   = state == CPE;
  assign write_enb_reg = state inside {LFD, LD, LAF, LP};
  assign busy          = !(state inside {DA, LD});
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed-step self-checking bench for router_fsm
module tb_router_fsm;
  logic clock = 0, reset = 1, pkt_valid = 0, fifo_full = 0;
  logic [1:0] data_in = 2'b00;
  logic fifo_empty_0 = 1, fifo_empty_1 = 1, fifo_empty_2 = 1;
  logic soft_reset_0 = 0, soft_reset_1 = 0, soft_reset_2 = 0;
  logic parity_done = 0, low_pkt_valid = 0;
  logic write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;
  int checks = 0, fails = 0;
  localparam logic [7:0] S_DA = 8'b0100_0000, S_LFD = 8'b1010_0001, S_LD = 8'b1001_0000,
    S_WTE = 8'b0000_0001, S_FFS = 8'b0000_0101, S_LAF = 8'b1000_1001,
    S_LP = 8'b1000_0001, S_CPE = 8'b0000_0011;
  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk_addr(input string tag, input logic [1:0] exp);
    checks++;
    assert (dut.addr_q === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, dut.addr_q, exp);
    end
  endtask
  initial begin
    tick(); tick();
    chk("reset", S_DA); chk_addr("reset_addr", 2'b00);
    reset = 0;
    pkt_valid = 1; data_in = 2'b10;
    tick(); chk("p1_lfd", S_LFD); chk_addr("p1_addr", 2'b10);
    for (int i = 0; i < 5; i++) begin
      tick(); chk($sformatf("p1_ld%0d", i), S_LD);
    end
    pkt_valid = 0;
    tick(); chk("p1_lp", S_LP);
    tick(); chk("p1_cpe", S_CPE);
    tick(); chk("p1_da", S_DA);
    fifo_empty_1 = 0; pkt_valid = 1; data_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("p2_wte%0d", i), S_WTE);
    end
    fifo_empty_1 = 1;
    tick(); chk("p2_lfd", S_LFD); chk_addr("p2_addr", 2'b01);
    tick(); chk("p2_ld", S_LD);
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("p2_ffs%0d", i), S_FFS);
    end
    fifo_full = 0; low_pkt_valid = 1; parity_done = 0;
    tick(); chk("p2_laf", S_LAF);
    pkt_valid = 0;
    tick(); chk("p2_lp", S_LP);
    low_pkt_valid = 0;
    tick(); chk("p2_cpe", S_CPE);
    tick(); chk("p2_da", S_DA);
    pkt_valid = 1; data_in = 2'b00;
    tick(); chk("p3_lfd", S_LFD);
    tick(); chk("p3_ld", S_LD);
    fifo_full = 1; pkt_valid = 0;
    tick(); chk("p3_full_prio", S_FFS);
    fifo_full = 0; parity_done = 1;
    tick(); chk("p3_laf", S_LAF);
    tick(); chk("p3_parity_done_da", S_DA);
    parity_done = 0; pkt_valid = 1; data_in = 2'b00;
    tick(); chk("p4_lfd", S_LFD);
    tick(); chk("p4_ld", S_LD);
    soft_reset_1 = 1;
    tick(); chk("p4_soft1_ignored", S_LD);
    soft_reset_1 = 0; soft_reset_0 = 1;
    tick(); chk("p4_soft0_da", S_DA);
    soft_reset_0 = 0; pkt_valid = 1; data_in = 2'b10;
    tick(); chk("p5_lfd", S_LFD);
    tick(); chk("p5_ld", S_LD);
    pkt_valid = 0;
    tick(); chk("p5_lp", S_LP);
    fifo_full = 1;
    tick(); chk("p5_cpe", S_CPE);
    tick(); chk("p5_cpe_to_ffs", S_FFS);
    fifo_full = 0;
    tick(); chk("p5_laf", S_LAF);
    tick(); chk("p5_laf_to_ld", S_LD);
    soft_reset_2 = 1;
    tick(); chk("p5_soft2_da", S_DA);
    soft_reset_2 = 0; pkt_valid = 1; data_in = 2'b11;
    tick(); chk("addr3_stay0", S_DA);
    tick(); chk("addr3_stay1", S_DA); chk_addr("addr3_hold", 2'b10);
    pkt_valid = 0;
    tick(); chk("idle_da", S_DA);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-sequencing controller for the 1x3 router ingress path.
- Tracks each incoming packet (header, payload, parity) and drives the register block's load, detect and reset strobes.
- Drives the write enable toward the three output FIFOs and the busy flag back to the source.
- Sits between the source interface and the register block / FIFO bank. All strobes are Moore outputs decoded from the current state.

Parameters:
- None. Three output ports, a 2-bit address field and address 2'b11 as invalid are fixed by the router architecture.

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  source asserts for header+payload, deasserts on the parity byte
- data_in  in  2  header address bits [1:0], sampled in DECODE_ADDRESS
- fifo_full  in  1  full flag of the currently addressed FIFO
- fifo_empty_0  in  1  FIFO 0 empty
- fifo_empty_1  in  1  FIFO 1 empty
- fifo_empty_2  in  1  FIFO 2 empty
- soft_reset_0  in  1  FIFO 0 read timeout
- soft_reset_1  in  1  FIFO 1 read timeout
- soft_reset_2  in  1  FIFO 2 read timeout
- parity_done  in  1  register block has captured the parity byte
- low_pkt_valid  in  1  register block saw pkt_valid fall while FIFO was full
- write_enb_reg  out  1  write strobe to the addressed FIFO
- detect_add  out  1  state == DECODE_ADDRESS
- lfd_state  out  1  state == LOAD_FIRST_DATA
- ld_state  out  1  state == LOAD_DATA
- laf_state  out  1  state == LOAD_AFTER_FULL
- full_state  out  1  state == FIFO_FULL_STATE
- rst_int_reg  out  1  state == CHECK_PARITY_ERROR
- busy  out  1  source must hold data_in stable while high

Behaviour:
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), WAIT_TILL_EMPTY (WTE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE).
- Reset: state=DA. detect_add=1; all other strobes, write_enb_reg and busy are 0. Latched address = 2'b00.
- Address latch: in DA, when pkt_valid=1 and data_in!=2'b11, addr_q<=data_in. addr_q is held until the next DA capture.
- Selected empty: the fifo_empty_n for n=data_in while in DA, and n=addr_q in all other states.
- DA:
  - pkt_valid & addr!=3 & empty -> LFD.
  - pkt_valid & addr!=3 & !empty -> WTE.
  - Otherwise stay. Address 3 is silently ignored.
- WTE: selected empty -> LFD; else stay.
- LFD: -> LD unconditionally (one cycle).
- LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay. fifo_full has priority over !pkt_valid.
- FFS: !fifo_full -> LAF; else stay.
- LAF:
  - parity_done -> DA.
  - !parity_done & low_pkt_valid -> LP.
  - !parity_done & !low_pkt_valid -> LD.
- LP: -> CPE unconditionally.
- CPE: fifo_full -> FFS; else -> DA.
- Soft reset: soft_reset_n with n==addr_q, in any state other than DA, forces next state DA. This has priority over every transition above except reset. soft_reset on a non-addressed port is ignored.
- write_enb_reg = LFD | LD | LAF | LP.
- busy = 1 in LFD, WTE, FFS, LAF, LP, CPE; 0 in DA and LD.
- Header latency: header accepted in DA at cycle t -> LFD at t+1 -> first payload in LD at t+2.
- Exactly one of detect_add/lfd_state/ld_state/laf_state/full_state/rst_int_reg is high in DA/LFD/LD/LAF/FFS/CPE. All six are low in WTE and LP.
- Unused state encodings: next state DA.

Test Plan:
- Reset held 2 cycles -> detect_add=1, busy=0, write_enb_reg=0, all other strobes 0.
- Header addr=2'b10, FIFO 2 empty, 5 payload bytes, then pkt_valid=0 -> DA,LFD,LD x5,LP,CPE,DA. write_enb_reg high for 7 cycles. rst_int_reg high 1 cycle. busy high in LFD/LP/CPE.
- Header addr=2'b01 with fifo_empty_1=0 for 4 cycles -> WTE for 4 cycles with busy=1. Then LFD on the cycle after fifo_empty_1 rises.
- In LD, fifo_full=1 for 3 cycles, then low, low_pkt_valid=1, parity_done=0 -> FFS x3 with full_state=1, LAF, LP, CPE, DA.
- In LD with addr_q=2'b00: soft_reset_1=1 -> no effect. Then soft_reset_0=1 -> DA next cycle, detect_add=1.
- Header data_in=2'b11 with pkt_valid=1 -> remains in DA, write_enb_reg=0, addr_q unchanged.
